regfile_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares one register-file write port (wr_en/wr_addr/wr_data) between NUM_REQ requesters, e.g. ALU writeback, load unit, CSR unit and debug.
- Each requester uses a valid/ready handshake.
- Exactly one request is accepted per cycle and driven to the register file as a registered write one cycle later.
- Sits between the writeback sources and the register file's write-enabled flip-flop banks.

---
 rtl/regfile_wr_arbiter.sv | 111 +++++++++++
 tb/tb_regfile_wr_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
//   Round-robin arbiter that shares a single register-file write port among
//   NUM_REQ writeback sources. One request is accepted per cycle and appears
//   on wr_* one cycle later. Writes to address 0 complete the handshake but
//   are not enabled on the register file.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   req_valid         per-requester valid
//   req_addr          packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_data          packed data,      requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready         one-hot combinational grant
//   wr_en/addr/data   registered register-file write port
//   grant_id          registered index of the requester shown on wr_*
//   conflict_cnt      (REGWR_ARB_CONFLICT_CNT_EN only) saturating count of
//                     cycles with two or more requests valid
//
// Optional feature macro: REGWR_ARB_CONFLICT_CNT_EN

module regfile_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          wr_en,
    output logic [ADDR_WIDTH-1:0]         wr_addr,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
`ifdef REGWR_ARB_CONFLICT_CNT_EN
    ,
    output logic [15:0]                   conflict_cnt
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0]       ptr;
    logic                  sel_found;
    logic [ID_W-1:0]       sel_idx;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [NUM_REQ-1:0]    grant_vec;
    logic [ID_W-1:0]       ptr_next;
    int                    idx;

    // Search from ptr upward, wrapping; the first valid requester wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_addr  = '0;
        sel_data  = '0;
        grant_vec = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!sel_found && req_valid[idx]) begin
                sel_found      = 1'b1;
                sel_idx        = idx[ID_W-1:0];
                sel_addr       = req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data       = req_data[idx*DATA_WIDTH +: DATA_WIDTH];
                grant_vec[idx] = 1'b1;
            end
        end
    end

    // Explicit wrap keeps this correct for non-power-of-two NUM_REQ.
    assign ptr_next  = (sel_idx == LAST_IDX) ? '0 : sel_idx + 1'b1;

    // Ready is masked during reset so nobody believes a handshake completed.
    assign req_ready = rst ? '0 : grant_vec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            grant_id <= '0;
            ptr      <= '0;
        end else if (sel_found) begin
            // x0 is hardwired zero: accept the request but do not write it.
            wr_en    <= (sel_addr != '0);
            wr_addr  <= sel_addr;
            wr_data  <= sel_data;
            grant_id <= sel_idx;
            ptr      <= ptr_next;
        end else begin
            wr_en    <= 1'b0;
        end
    end

`ifdef REGWR_ARB_CONFLICT_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (($countones(req_valid) >= 2) && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter (NUM_REQ=4, DATA_WIDTH=32,
// ADDR_WIDTH=5). Table rows hold one cycle of stimulus with the expected
// combinational grant and the wr_* values expected after the following edge.
module tb_regfile_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int AW = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic [1:0]       grant_id;
`ifdef REGWR_ARB_CONFLICT_CNT_EN
    logic [15:0]      conflict_cnt;
`endif

    regfile_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .grant_id  (grant_id)
`ifdef REGWR_ARB_CONFLICT_CNT_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NR*AW-1:0] pack_a(input logic [AW-1:0] a3, a2, a1, a0);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [NR*DW-1:0] pack_d(input logic [DW-1:0] d3, d2, d1, d0);
        return {d3, d2, d1, d0};
    endfunction

    typedef struct {
        logic [NR-1:0]    valid;
        logic [NR*AW-1:0] addr;
        logic [NR*DW-1:0] data;
        logic [NR-1:0]    exp_ready;
        logic             exp_en;
        logic [AW-1:0]    exp_addr;
        logic [DW-1:0]    exp_data;
        logic [1:0]       exp_gid;
    } vec_t;

    localparam int NV = 18;
    vec_t vt [NV];

    initial begin
        logic [NR*AW-1:0] da;
        logic [NR*DW-1:0] dd;
        da = pack_a(5'd4, 5'd3, 5'd2, 5'd1);
        dd = pack_d(32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000);

        // single requester, ptr 0 -> 3
        vt[0] = '{4'b0100, pack_a(5'd4, 5'd7, 5'd2, 5'd1),
                  pack_d(32'hC0DE0003, 32'hDEADBEEF, 32'hC0DE0001, 32'hC0DE0000),
                  4'b0100, 1'b1, 5'd7, 32'hDEADBEEF, 2'd2};
        // idle: wr_en drops, everything else holds
        vt[1] = '{4'b0000, da, dd, 4'b0000, 1'b0, 5'd7, 32'hDEADBEEF, 2'd2};
        // ptr 3 with 0011: wrap to 0, then 1
        vt[2] = '{4'b0011, da, dd, 4'b0001, 1'b1, 5'd1, 32'hC0DE0000, 2'd0};
        vt[3] = '{4'b0011, da, dd, 4'b0010, 1'b1, 5'd2, 32'hC0DE0001, 2'd1};
        // ptr 2, only 3 valid: skip ahead, ptr wraps to 0
        vt[4] = '{4'b1000, da, dd, 4'b1000, 1'b1, 5'd4, 32'hC0DE0003, 2'd3};
        // fairness: all valid for 8 cycles from ptr 0
        for (int k = 0; k < 8; k++) begin
            vt[5+k] = '{4'b1111, da, dd, 4'(1 << (k % 4)), 1'b1,
                        5'(k % 4 + 1), 32'hC0DE0000 + 32'(k % 4), 2'(k % 4)};
        end
        // x0: granted, no write, ptr -> 2
        vt[13] = '{4'b0010, pack_a(5'd4, 5'd3, 5'd0, 5'd1),
                   pack_d(32'hC0DE0003, 32'hC0DE0002, 32'h12345678, 32'hC0DE0000),
                   4'b0010, 1'b0, 5'd0, 32'h12345678, 2'd1};
        // confirms ptr advanced to 2 after the x0 grant
        vt[14] = '{4'b0111, da, dd, 4'b0100, 1'b1, 5'd3, 32'hC0DE0002, 2'd2};
        vt[15] = '{4'b0011, da, dd, 4'b0001, 1'b1, 5'd1, 32'hC0DE0000, 2'd0};
        // same address back-to-back, emitted in grant order
        vt[16] = '{4'b0110, pack_a(5'd4, 5'd9, 5'd9, 5'd1),
                   pack_d(32'hC0DE0003, 32'hBBBB0002, 32'hAAAA0001, 32'hC0DE0000),
                   4'b0010, 1'b1, 5'd9, 32'hAAAA0001, 2'd1};
        vt[17] = '{4'b0100, pack_a(5'd4, 5'd9, 5'd9, 5'd1),
                   pack_d(32'hC0DE0003, 32'hBBBB0002, 32'hAAAA0001, 32'hC0DE0000),
                   4'b0100, 1'b1, 5'd9, 32'hBBBB0002, 2'd2};

        // ---- reset state ----
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_addr  = da;
        req_data  = dd;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_wr_en", 64'(wr_en), 64'h0);
        chk("rst_wr_addr", 64'(wr_addr), 64'h0);
        chk("rst_wr_data", 64'(wr_data), 64'h0);
        chk("rst_grant_id", 64'(grant_id), 64'h0);
`ifdef REGWR_ARB_CONFLICT_CNT_EN
        chk("rst_conflict_cnt", 64'(conflict_cnt), 64'h0);
`endif
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(req_ready), 64'h1);
        req_valid = 4'b0000;
        @(posedge clk);
        #1;
        chk("post_rst_idle_wr_en", 64'(wr_en), 64'h0);

        // ---- table ----
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            req_valid = vt[i].valid;
            req_addr  = vt[i].addr;
            req_data  = vt[i].data;
            #1;
            chk($sformatf("v%0d_ready", i), 64'(req_ready), 64'(vt[i].exp_ready));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_wr_en", i), 64'(wr_en), 64'(vt[i].exp_en));
            chk($sformatf("v%0d_wr_addr", i), 64'(wr_addr), 64'(vt[i].exp_addr));
            chk($sformatf("v%0d_wr_data", i), 64'(wr_data), 64'(vt[i].exp_data));
            chk($sformatf("v%0d_grant_id", i), 64'(grant_id), 64'(vt[i].exp_gid));
        end

        // ---- reset mid-write (ptr is 3 here) ----
        @(negedge clk);
        req_valid = 4'b0010;
        req_addr  = da;
        req_data  = dd;
        #1;
        chk("mid_ready", 64'(req_ready), 64'h2);
        @(posedge clk);
        #1;
        chk("mid_accept_wr_en", 64'(wr_en), 64'h1);
        chk("mid_accept_gid", 64'(grant_id), 64'h1);
        #4;
        rst = 1'b1;
        #1;
        chk("mid_rst_wr_en", 64'(wr_en), 64'h0);
        chk("mid_rst_ready", 64'(req_ready), 64'h0);
        chk("mid_rst_wr_addr", 64'(wr_addr), 64'h0);
        #2;
        rst       = 1'b0;
        req_valid = 4'b1001;
        #1;
        chk("mid_release_wr_en", 64'(wr_en), 64'h0);
        chk("mid_release_ready", 64'(req_ready), 64'h1);
        @(posedge clk);
        #1;
        chk("mid_first_wr_en", 64'(wr_en), 64'h1);
        chk("mid_first_gid", 64'(grant_id), 64'h0);
        chk("mid_first_addr", 64'(wr_addr), 64'h1);

`ifdef REGWR_ARB_CONFLICT_CNT_EN
        // ---- conflict counter: fresh reset, 10 cycles of 0110 ----
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 4'b0110;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        req_valid = 4'b0000;
        chk("conflict_cnt_10", 64'(conflict_cnt), 64'd10);
        @(posedge clk);
        #1;
        chk("conflict_cnt_hold", 64'(conflict_cnt), 64'd10);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
